// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: D-stage feedback,
// the hazard stall, instruction-memory access and the IF/ID register outputs.
interface if_stage_if;
  logic [1:0]  pc_sel;
  logic        jump_D;
  logic [25:0] imm26_D;
  logic [31:0] pc_D_in;
  logic [31:0] rd1_D;
  logic        stall;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        valid_D;
  logic        fetch_err;

  modport master (
    output pc_sel, jump_D, imm26_D, pc_D_in, rd1_D, stall, instr_F,
    input  pc_F, instr_D, pc_D, pc8_D, valid_D, fetch_err
  );

  modport slave (
    input  pc_sel, jump_D, imm26_D, pc_D_in, rd1_D, stall, instr_F,
    output pc_F, instr_D, pc_D, pc8_D, valid_D, fetch_err
  );
endinterface

// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC selection, IF/ID register and a sticky
// fetch-address error flag. Branch delay slot is implicit (no flush).
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.slave  bus
);

  localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

  logic [31:0] pc_q;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;
  logic        err_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        next_bad;

  assign br_off = {{14{bus.imm26_D[15]}}, bus.imm26_D[15:0], 2'b00};

  always_comb begin
    next_pc = bus.pc_F + 32'd4;
    case (bus.pc_sel)
      2'b01: begin
        if (bus.jump_D) next_pc = {bus.pc_D_in[31:28], bus.imm26_D, 2'b00};
        else            next_pc = bus.pc_D_in + 32'd4 + br_off;
      end
      2'b10:   next_pc = bus.rd1_D;
      default: next_pc = bus.pc_F + 32'd4;
    endcase
  end

  assign next_bad = (next_pc[1:0] != 2'b00) || (next_pc < IM_BASE) || (next_pc > IM_LAST);

  // Stall freezes everything, so a pending redirect is simply re-evaluated later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      instr_d_q <= 32'd0;
      pc_d_q    <= 32'd0;
      valid_d_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (!bus.stall) begin
      pc_q      <= next_pc;
      instr_d_q <= bus.instr_F;
      pc_d_q    <= pc_q;
      valid_d_q <= 1'b1;
      if (next_bad) err_q <= 1'b1;
    end
  end

  assign bus.pc_F      = pc_q;
  assign bus.instr_D   = instr_d_q;
  assign bus.pc_D      = pc_d_q;
  assign bus.pc8_D     = pc_d_q + 32'd8;
  assign bus.valid_D   = valid_d_q;
  assign bus.fetch_err = err_q;

endmodule
